// File: rtl/flash_loader.sv
// flash_loader: SPI flash boot engine that copies one game slot into cartridge SPRAM.
//   clock, reset         system clock, asynchronous active-high reset
//   reload, index        one-cycle load request and the slot number it loads
//   load_done, flags_out image-complete flag and the slot's 32-bit header word
//   wr_en/wr_addr/wr_data  SPRAM byte-write port (PRG at 0x00000, CHR at 0x10000)
//   flash_csn/sck/mosi/miso  SPI mode-0 master port to the flash
module flash_loader #(
    parameter logic [23:0] FLASH_BASE  = 24'h100000,
    parameter int          SLOT_SHIFT  = 18,
    parameter int          LOAD_BYTES  = 131072,
    parameter int          WAKE_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reload,
    input  logic [3:0]  index,
    output logic        load_done,
    output logic [31:0] flags_out,
    output logic        wr_en,
    output logic [16:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        flash_csn,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);
    localparam logic [2:0] ST_START     = 3'd0;
    localparam logic [2:0] ST_WAKE_CMD  = 3'd1;
    localparam logic [2:0] ST_WAKE_WAIT = 3'd2;
    localparam logic [2:0] ST_READ_CMD  = 3'd3;
    localparam logic [2:0] ST_HEADER    = 3'd4;
    localparam logic [2:0] ST_DATA      = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;
    localparam logic [2:0] ST_IDLE      = 3'd7;

    logic [2:0]  r_state;
    logic [4:0]  r_bits;
    logic [15:0] r_wait;
    logic [31:0] r_tx;
    logic [31:0] r_rx;
    logic [3:0]  r_index;
    logic [16:0] r_byte;

    logic        w_start;
    logic        w_xfer;
    logic        w_last_bit;
    logic [31:0] w_rx_next;
    logic [23:0] w_slot_addr;

    // ST_START is the reset state, so a boot load needs no reload pulse.
    assign w_start     = (r_state == ST_START) || (r_state == ST_IDLE && reload);
    assign w_xfer      = (r_state == ST_WAKE_CMD) || (r_state == ST_READ_CMD) ||
                         (r_state == ST_HEADER) || (r_state == ST_DATA);
    assign w_last_bit  = (r_state == ST_WAKE_CMD) ? (r_bits == 5'd7) : (r_bits == 5'd31);
    assign w_rx_next   = {r_rx[30:0], flash_miso};
    assign w_slot_addr = FLASH_BASE + (24'(r_index) << SLOT_SHIFT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_START;
            r_bits     <= '0;
            r_wait     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_index    <= '0;
            r_byte     <= '0;
            load_done  <= 1'b0;
            flags_out  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            flash_csn  <= 1'b1;
            flash_sck  <= 1'b0;
            flash_mosi <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (w_start) begin
                r_index    <= index;
                load_done  <= 1'b0;
                flash_csn  <= 1'b0;
                flash_mosi <= 1'b1;
                r_tx       <= {8'hAB, 24'h0};
                r_bits     <= '0;
                r_byte     <= '0;
                r_state    <= ST_WAKE_CMD;
            end else if (w_xfer) begin
                if (!flash_sck) begin
                    // Rising SCK edge: sample MISO on the same clock edge.
                    flash_sck <= 1'b1;
                    r_rx      <= w_rx_next;
                    // Header is little-endian; first byte sits in the top of the shifter.
                    if (r_state == ST_HEADER && r_bits == 5'd31)
                        flags_out <= {w_rx_next[7:0], w_rx_next[15:8], w_rx_next[23:16], w_rx_next[31:24]};
                end else begin
                    flash_sck  <= 1'b0;
                    flash_mosi <= r_tx[30];
                    r_tx       <= {r_tx[30:0], 1'b0};
                    r_bits     <= r_bits + 5'd1;
                    if (r_state == ST_DATA && r_bits[2:0] == 3'd7) begin
                        wr_en   <= 1'b1;
                        wr_addr <= r_byte;
                        wr_data <= r_rx[7:0];
                        r_byte  <= r_byte + 17'd1;
                        if (r_byte == 17'(LOAD_BYTES - 1)) begin
                            flash_csn <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end else if (r_state != ST_DATA && w_last_bit) begin
                        if (r_state == ST_WAKE_CMD) begin
                            flash_csn <= 1'b1;
                            r_wait    <= '0;
                            r_state   <= ST_WAKE_WAIT;
                        end else if (r_state == ST_READ_CMD) begin
                            r_state <= ST_HEADER;
                        end else begin
                            r_byte  <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                end
            end else if (r_state == ST_WAKE_WAIT) begin
                r_wait <= r_wait + 16'd1;
                if (r_wait == 16'(WAKE_CYCLES - 1)) begin
                    flash_csn  <= 1'b0;
                    flash_mosi <= 1'b0;
                    r_tx       <= {8'h03, w_slot_addr};
                    r_bits     <= '0;
                    r_state    <= ST_READ_CMD;
                end
            end else if (r_state == ST_DONE) begin
                load_done <= 1'b1;
                r_state   <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: scoreboard bench for flash_loader with an SPI flash model.
module tb_flash_loader;
    localparam int NB = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reload = 1'b0;
    logic [3:0]  index = 4'd2;
    logic        load_done, wr_en, csn, sck, mosi;
    logic        miso = 1'b0;
    logic [31:0] flags_out;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;

    logic        load_done_b, wr_en_b, csn_b, sck_b, mosi_b;
    logic [31:0] flags_b;
    logic [16:0] wr_addr_b;
    logic [7:0]  wr_data_b;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    flash_loader #(.LOAD_BYTES(NB)) dut (
        .clock(clk), .reset(rst), .reload(reload), .index(index),
        .load_done(load_done), .flags_out(flags_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flash_csn(csn), .flash_sck(sck), .flash_mosi(mosi), .flash_miso(miso)
    );

    flash_loader #(.FLASH_BASE(24'hF00000), .LOAD_BYTES(NB)) dut_b (
        .clock(clk), .reset(rst), .reload(1'b0), .index(4'd15),
        .load_done(load_done_b), .flags_out(flags_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .flash_csn(csn_b), .flash_sck(sck_b), .flash_mosi(mosi_b), .flash_miso(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] flags_for(input logic [23:0] a);
        return (a == 24'h180000) ? 32'h12345678 : {a[23:16], 24'hA5C3E1};
    endfunction

    function automatic logic [7:0] stream_byte(input int b, input logic [23:0] a);
        logic [31:0] f;
        f = flags_for(a);
        return (b < 4) ? 8'(f >> (8 * b)) : 8'((b - 4) ^ 32'h5A);
    endfunction

    // Flash model and scoreboard for the main DUT.
    logic [24:0] q[$];
    logic [24:0] e;
    logic [31:0] cmd = '0;
    logic [23:0] rd_addr = '0;
    logic [31:0] prev_flags = '0;
    logic [7:0]  cur;
    logic        prev_sck = 1'b0, prev_csn = 1'b1;
    int bitn = 0, pos, cyc = 0, hi_run = 0, last_hi = 0, last_wr = -1;
    int reads = 0, wcount = 0, first_addr = -1, sck_viol = 0, rst_wr = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) q.delete();
        if (csn && sck) sck_viol++;
        if (csn && !prev_csn && bitn == 8) check("wake_byte", {24'h0, cmd[7:0]}, 32'hAB);
        if (csn) begin
            bitn = 0;
            hi_run++;
        end else begin
            if (prev_csn) begin
                last_hi = hi_run;
                hi_run = 0;
            end
            if (sck && !prev_sck) begin
                if (bitn < 32) cmd = {cmd[30:0], mosi};
                bitn++;
                if (bitn == 32 && cmd[31:24] == 8'h03) begin
                    rd_addr = cmd[23:0];
                    reads++;
                    wcount = 0;
                    last_wr = -1;
                    check("csn_high_gap", last_hi, 64);
                end
                if (bitn >= 72 && (bitn - 64) % 8 == 0 && cmd[31:24] == 8'h03)
                    q.push_back({17'((bitn - 72) / 8), 8'(((bitn - 72) / 8) ^ 32'h5A)});
            end
        end
        if (!rst && flags_out != prev_flags) check("flags_at_hdr4", bitn, 64);
        prev_flags = flags_out;
        if (wr_en) begin
            if (rst) rst_wr++;
            check("wr_queued", {31'h0, q.size() != 0}, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("wr_addr", {15'h0, wr_addr}, {15'h0, e[24:8]});
                check("wr_data", {24'h0, wr_data}, {24'h0, e[7:0]});
            end
            if (last_wr >= 0) check("wr_gap", cyc - last_wr, 16);
            if (wcount == 0) first_addr = int'(wr_addr);
            last_wr = cyc;
            wcount++;
        end
        prev_sck = sck;
        prev_csn = csn;
        pos = bitn - 32;
        if (!csn && bitn >= 32 && cmd[31:24] == 8'h03) begin
            cur = stream_byte(pos / 8, rd_addr);
            miso = cur[7 - pos % 8];
        end else miso = 1'b0;
    end

    // Light monitor for the wrapped-address DUT.
    logic [31:0] cmd_b = '0;
    logic [23:0] rd_b = '0;
    logic        prev_sck_b = 1'b0, final_b = 1'b0;
    int bitn_b = 0, count_b = 0, last_b = -1, after_b = 0;

    always @(negedge clk) begin
        if (rst) begin
            final_b = 1'b0;
            count_b = 0;
        end
        if (csn_b) bitn_b = 0;
        else if (sck_b && !prev_sck_b) begin
            if (bitn_b < 32) cmd_b = {cmd_b[30:0], mosi_b};
            bitn_b++;
            if (bitn_b == 32 && cmd_b[31:24] == 8'h03) rd_b = cmd_b[23:0];
        end
        prev_sck_b = sck_b;
        if (wr_en_b) begin
            if (final_b) after_b++;
            count_b++;
            last_b = int'(wr_addr_b);
            if (wr_addr_b == 17'(NB - 1)) final_b = 1'b1;
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!load_done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'h0, load_done}, 1);
    endtask

    task automatic wait_writes(input int r, input int w, input string tag);
        int n;
        n = 0;
        while (!(reads == r && wcount >= w) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'h0, reads == r && wcount >= w}, 1);
    endtask

    task automatic pulse_reload(input logic [3:0] idx);
        @(negedge clk);
        index = idx;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csn"}, {31'h0, csn}, 1);
        check({tag, "_sck"}, {31'h0, sck}, 0);
        check({tag, "_mosi"}, {31'h0, mosi}, 0);
        check({tag, "_wr_en"}, {31'h0, wr_en}, 0);
        check({tag, "_done"}, {31'h0, load_done}, 0);
        check({tag, "_wr_addr"}, {15'h0, wr_addr}, 0);
        check({tag, "_wr_data"}, {24'h0, wr_data}, 0);
        check({tag, "_flags"}, flags_out, 0);
    endtask

    int reads_before;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        wait_done("boot_done");
        check("boot_addr", {8'h0, rd_addr}, 32'h180000);
        check("boot_flags", flags_out, 32'h12345678);
        check("boot_writes", wcount, NB);
        check("boot_first", first_addr, 0);
        repeat (4) @(negedge clk);
        check("b_done", {31'h0, load_done_b}, 1);
        check("b_addr", {8'h0, rd_b}, 32'h2C0000);
        check("b_writes", count_b, NB);
        check("b_last", last_b, NB - 1);

        pulse_reload(4'd5);
        check("reload_drop", {31'h0, load_done}, 0);
        wait_done("slot5_done");
        check("slot5_addr", {8'h0, rd_addr}, 32'h240000);
        check("slot5_flags", flags_out, flags_for(24'h240000));
        check("slot5_writes", wcount, NB);

        pulse_reload(4'd1);
        wait_writes(reads + 1, 10, "slot1_data");
        reads_before = reads;
        pulse_reload(4'd7);
        wait_done("slot1_done");
        check("slot1_addr", {8'h0, rd_addr}, 32'h140000);
        check("slot1_flags", flags_out, flags_for(24'h140000));
        check("slot1_writes", wcount, NB);
        repeat (200) @(negedge clk);
        check("no_second_load", reads, reads_before);
        check("still_done", {31'h0, load_done}, 1);

        pulse_reload(4'd3);
        wait_writes(reads + 1, 20, "slot3_data");
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_done("restart_done");
        check("restart_addr", {8'h0, rd_addr}, 32'h1C0000);
        check("restart_first", first_addr, 0);
        check("restart_writes", wcount, NB);
        repeat (40) @(negedge clk);

        check("sck_idle_viol", sck_viol, 0);
        check("writes_in_reset", rst_wr, 0);
        check("b_after_final", after_b, 0);
        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/flash_loader.md
# flash_loader

SPI flash boot engine for the NES cartridge memory. On reset release, or on a `reload` pulse, it reads one game slot from the external SPI flash and extracts that game's 32-bit mapper/flags word. It then streams the slot's PRG+CHR image into the 128 kB cartridge SPRAM through a byte-write port. It sits directly upstream of the cartridge memory: its write port and `load_done` are the only path by which ROM contents reach the PRG/CHR segments that the NES memory map reads.

## Interface
Parameters:
- `FLASH_BASE`, 24'h100000, flash byte address of slot 0.
- `SLOT_SHIFT`, 18, log2 of the slot stride in bytes. Slot n starts at `FLASH_BASE + (n << SLOT_SHIFT)`, computed modulo 2^24.
- `LOAD_BYTES`, 131072, image bytes written per load (PRG 64 kB, then CHR 64 kB).
- `WAKE_CYCLES`, 64, clocks `flash_csn` is held high after the release-power-down command.

Ports:
- `clock`  in  1  system clock. Every state change happens on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reload`  in  1  single-cycle request to load slot `index`.
- `index`  in  4  slot number. Latched on the cycle a load starts.
- `load_done`  out  1  high when the SPRAM holds a complete image.
- `flags_out`  out  32  flags header of the last loaded slot.
- `wr_en`  out  1  one-cycle SPRAM byte-write strobe.
- `wr_addr`  out  17  SPRAM byte address. 0–0xFFFF is PRG, 0x10000–0x1FFFF is CHR.
- `wr_data`  out  8  byte to write.
- `flash_csn`  out  1  flash chip select, active low.
- `flash_sck`  out  1  SPI clock, mode 0.
- `flash_mosi`  out  1  SPI data to the flash.
- `flash_miso`  in  1  SPI data from the flash.

## Operation
- States and transitions:
  - WAKE_CMD: shift out 0xAB.
  - WAKE_WAIT: `flash_csn` high for `WAKE_CYCLES` clocks.
  - READ_CMD: shift out 0x03 followed by the 24-bit slot address, MSB first. 32 bits.
  - HEADER: shift in 4 bytes.
  - DATA: shift in `LOAD_BYTES` bytes.
  - DONE: raise `flash_csn`, go to IDLE.
  - IDLE: `flash_csn`=1, `flash_sck`=0. Wait for `reload`.
- After reset deassert, the block enters WAKE_CMD automatically with `index` latched. Cartridge SPRAM contents are undefined until the first load completes.
- `reload` in IDLE: latch `index`, drop `load_done`, go to WAKE_CMD.
- `reload` in any other state is ignored. It is not queued.
- Header bytes are little-endian: the first byte read goes to `flags_out[7:0]`, the fourth to `[31:24]`.
  - `flags_out` is updated atomically, in one cycle, when the 4th header byte completes.
  - Between updates `flags_out` holds its old value. Partial header bytes never appear on it.
- Data byte k (0-based) produces exactly one `wr_en` pulse with `wr_addr`=k and `wr_data` = that byte, MSB received first.
  - Header bytes never produce `wr_en`.
  - `wr_addr` and `wr_data` hold their last values when `wr_en`=0.
- The byte counter is 17 bits. The block leaves DATA when the counter reaches `LOAD_BYTES`-1 and that byte has been written. No wrap-around write to address 0 ever occurs.
- `load_done` rises the cycle after the final `wr_en` and stays high until the next load starts.

## Timing
- Each SPI bit takes 2 clocks:
  - Phase L: `flash_sck`=0, `flash_mosi` updated.
  - Phase H: `flash_sck`=1.
  - `flash_miso` is registered on the clock edge that takes `flash_sck` from 0 to 1.
- `flash_csn` falls together with the first phase L of a command. It rises on the edge after the last phase H of that transfer.
- `flash_sck` is 0 whenever `flash_csn` is 1.
- Cycle counts:
  - One byte is 16 clocks.
  - WAKE_CMD is 16 clocks and READ_CMD is 64 clocks.
  - `wr_en` for byte k asserts the clock after that byte's 8th sample.
  - Consecutive `wr_en` pulses are exactly 16 clocks apart.
  - A full load is 16 + `WAKE_CYCLES` + 64 + 16·(4+`LOAD_BYTES`) clocks, plus a fixed overhead of at most 4 clocks.
- Reset values, all applied asynchronously:
  - `flash_csn`=1; `flash_sck`, `flash_mosi`, `wr_en`, `load_done` = 0.
  - `wr_addr`=0, `wr_data`=0, `flags_out`=0.
  - State, counters and the latched index are cleared.
- Reset mid-load: outputs return to reset values immediately, and a fresh load starts after deassert. There is no stray `wr_en`.

## Test plan
- Boot load: `index`=2 at reset release, with a flash model holding flags 0x12345678 and data pattern (addr^0x5A). Required response:
  - READ_CMD shifts 0x03 then 0x180000.
  - `flags_out`=0x12345678.
  - 131072 writes with `wr_data`=(k^0x5A) at `wr_addr`=k.
  - `load_done`=1 afterwards.
- Bit timing: monitor SCK/CSN and check the following.
  - `flash_sck`=0 whenever CSN is high.
  - Wake byte is 0xAB.
  - CSN is high for 64 clocks before the read.
  - `wr_en` pulses are exactly 16 clocks apart.
- Reload: after a completed load, pulse `reload` with `index`=5. Required response:
  - `load_done` drops the next cycle.
  - Read address is 0x240000.
  - `flags_out` changes only at the 4th header byte.
- Ignored reload: pulse `reload` with `index`=7 during DATA of a slot-1 load. The slot-1 load must finish unchanged, and there is no second load.
- Mid-load reset: assert `reset` in DATA at byte 1000. Required response:
  - All outputs are at reset values in the same cycle.
  - After deassert, a full load restarts from `wr_addr`=0.
  - No write occurs while reset is asserted.
- Slot address wrap: `FLASH_BASE`=24'hF00000, `index`=15. Required response:
  - Address is (0xF00000 + 15<<18) mod 2^24 = 0x2C0000.
  - The final write is at address 0x1FFFF.
  - No write occurs at address 0 after it.
